// File: rtl/swo_uart_rx.sv
// NRZ/UART receiver for the SWO pin: recovers 8-bit LSB-first frames with a
// programmable bit period and counts framing errors.
module swo_uart_rx #(
  parameter int pDIV_WIDTH = 16
) (
  input  logic                  fe_clk,
  input  logic                  reset,
  input  logic                  I_enable,
  input  logic [pDIV_WIDTH-1:0] I_baud_div,
  input  logic                  swo,
  output logic [7:0]            O_data,
  output logic                  O_data_valid,
  output logic                  O_frame_error,
  output logic [7:0]            O_error_count,
  output logic                  O_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRKWAIT
  } state_t;

  localparam logic [pDIV_WIDTH-1:0] MIN_DIV = pDIV_WIDTH'(3);
  localparam logic [pDIV_WIDTH-1:0] ONE     = pDIV_WIDTH'(1);
  localparam logic [pDIV_WIDTH-1:0] ZERO    = '0;

  state_t                  state_q, state_d;
  logic [1:0]              sync_q;
  logic [pDIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [pDIV_WIDTH-1:0]   de_q, de_d;
  logic [2:0]              bit_q, bit_d;
  logic [7:0]              shift_q, shift_d;
  logic [7:0]              data_q, data_d;
  logic                    vld_q, vld_d;
  logic                    ferr_q, ferr_d;
  logic [7:0]              errcnt_q, errcnt_d;
  logic                    swo_s;
  logic [pDIV_WIDTH-1:0]   de_eff;

  assign swo_s  = sync_q[1];
  // Divisors below 3 leave no room for a mid-bit sample, so clamp them.
  assign de_eff = (I_baud_div < MIN_DIV) ? MIN_DIV : I_baud_div;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    de_d     = de_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    vld_d    = 1'b0;
    ferr_d   = 1'b0;
    errcnt_d = errcnt_q;
    if (!I_enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!swo_s) begin
            state_d = S_START;
            de_d    = de_eff;
            cnt_d   = de_eff >> 1;
          end
        end
        S_START: begin
          if (cnt_q == ZERO) begin
            if (!swo_s) begin
              state_d = S_DATA;
              cnt_d   = de_q;
              bit_d   = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == ZERO) begin
            shift_d = {swo_s, shift_q[7:1]};
            cnt_d   = de_q;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        S_STOP: begin
          if (cnt_q == ZERO) begin
            if (swo_s) begin
              vld_d   = 1'b1;
              data_d  = shift_q;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
              state_d = S_BRKWAIT;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        // A held-low break is reported once; wait for the line to recover.
        S_BRKWAIT: begin
          if (swo_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge fe_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      de_q     <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      ferr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], swo};
      cnt_q    <= cnt_d;
      de_q     <= de_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      ferr_q   <= ferr_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign O_data        = data_q;
  assign O_data_valid  = vld_q;
  assign O_frame_error = ferr_q;
  assign O_error_count = errcnt_q;
  assign O_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_swo_uart_rx.sv
// Bench for swo_uart_rx: drives UART frames on swo and compares received
// strobes against a frame-level reference model.
module tb_swo_uart_rx;

  logic        fe_clk = 1'b0;
  logic        reset;
  logic        I_enable;
  logic [15:0] I_baud_div;
  logic        swo;
  logic [7:0]  O_data;
  logic        O_data_valid;
  logic        O_frame_error;
  logic [7:0]  O_error_count;
  logic        O_busy;

  swo_uart_rx #(.pDIV_WIDTH(16)) dut (
    .fe_clk        (fe_clk),
    .reset         (reset),
    .I_enable      (I_enable),
    .I_baud_div    (I_baud_div),
    .swo           (swo),
    .O_data        (O_data),
    .O_data_valid  (O_data_valid),
    .O_frame_error (O_frame_error),
    .O_error_count (O_error_count),
    .O_busy        (O_busy)
  );

  always #5 fe_clk = ~fe_clk;

  int cyc = 0;
  always @(posedge fe_clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } ev_t;

  ev_t obs[$];
  ev_t exp_q[$];
  int  both_cnt = 0;
  int  busy_cnt = 0;
  int  total = 0;
  int  bad = 0;
  int  model_errs = 0;
  logic [7:0] last_data = 8'h00;

  // Observed strobes, sampled away from the active edge.
  always @(negedge fe_clk) begin
    if (!reset) begin
      if (O_data_valid)  obs.push_back('{1'b0, O_data, cyc});
      if (O_frame_error) obs.push_back('{1'b1, O_data, cyc});
      if (O_data_valid && O_frame_error) both_cnt++;
      if (O_busy) busy_cnt++;
    end
  end

  // Reference model: one event per frame, decided only by its stop bit.
  task automatic model_frame(input logic [7:0] b, input logic stopb);
    if (stopb) begin
      exp_q.push_back('{1'b0, b, 0});
      last_data = b;
    end else begin
      exp_q.push_back('{1'b1, 8'h00, 0});
      model_errs++;
    end
  endtask

  function automatic logic [7:0] model_errcnt();
    return (model_errs > 255) ? 8'hFF : 8'(model_errs);
  endfunction

  task automatic drive(input logic v, input int n);
    swo = v;
    repeat (n) @(posedge fe_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stopb, input int p);
    drive(1'b0, p);
    for (int i = 0; i < 8; i++) drive(b[i], p);
    drive(stopb, p);
    swo = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; I_enable = 1'b0; swo = 1'b1; I_baud_div = 16'd15;
    repeat (3) @(posedge fe_clk);
    #1;
    total++; if (O_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", O_data); end
    total++; if (O_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", O_data_valid); end
    total++; if (O_frame_error !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", O_frame_error); end
    total++; if (O_error_count !== 8'h00) begin bad++; $display("FAIL reset_errcnt: got %0d want 0", O_error_count); end
    total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", O_busy); end
    reset = 1'b0; I_enable = 1'b1;
    drive(1'b1, 5);
  endtask

  task automatic test_single;
    int c0;
    obs.delete(); exp_q.delete();
    I_baud_div = 16'd15;
    c0 = cyc;
    send(8'hA5, 1'b1, 16); model_frame(8'hA5, 1'b1);
    drive(1'b1, 20);
    total++; if (obs.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", obs.size()); end
    if (obs.size() > 0) begin
      total++; if (obs[0].is_err !== 1'b0 || obs[0].data !== 8'hA5) begin
        bad++; $display("FAIL single_data: got err=%b %0h want err=0 a5", obs[0].is_err, obs[0].data); end
      // Fall captured 3 edges later (t0), then 1+(15>>1)+9*16 edges to the stop sample.
      total++; if (obs[0].at !== c0 + 3 + 1 + 7 + 144) begin
        bad++; $display("FAIL single_time: got %0d want %0d", obs[0].at - c0, 155); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
    obs.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin send(bytes[i], 1'b1, 16); model_frame(bytes[i], 1'b1); end
    drive(1'b1, 20);
    total++; if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++; if (obs[i].is_err !== 1'b0 || obs[i].data !== exp_q[i].data) begin
        bad++; $display("FAIL b2b_byte%0d: got err=%b %0h want %0h", i, obs[i].is_err, obs[i].data, exp_q[i].data); end
    end
  endtask

  task automatic test_glitch;
    obs.delete();
    busy_cnt = 0;
    drive(1'b0, 5);
    drive(1'b1, 40);
    total++; if (obs.size() !== 0) begin bad++; $display("FAIL glitch_strobes: got %0d want 0", obs.size()); end
    total++; if (busy_cnt !== 8) begin bad++; $display("FAIL glitch_busy: got %0d want 8", busy_cnt); end
  endtask

  task automatic test_break;
    logic [7:0] b;
    obs.delete(); exp_q.delete();
    b = 8'($urandom);
    send(b, 1'b0, 16); model_frame(b, 1'b0);
    drive(1'b0, 50 * 16);
    drive(1'b1, 10);
    total++; if (obs.size() !== 1 || obs.size() > 0 && obs[0].is_err !== 1'b1) begin
      bad++; $display("FAIL break_one_error: got %0d events want 1 error", obs.size()); end
    total++; if (O_error_count !== model_errcnt()) begin bad++; $display("FAIL break_errcnt: got %0d want %0d", O_error_count, model_errcnt()); end
    total++; if (O_data !== last_data) begin bad++; $display("FAIL break_data_held: got %0h want %0h", O_data, last_data); end
    send(8'h3C, 1'b1, 16); model_frame(8'h3C, 1'b1);
    drive(1'b1, 20);
    total++; if (obs.size() !== 2 || obs.size() == 2 && (obs[1].is_err !== 1'b0 || obs[1].data !== 8'h3C)) begin
      bad++; $display("FAIL break_recover: got %0d events last=%0h want 2 events last=3c", obs.size(), O_data); end
  endtask

  task automatic test_saturate;
    int nerr;
    obs.delete(); exp_q.delete();
    I_baud_div = 16'd3;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 1'b0, 4); model_frame(8'h00, 1'b0);
      drive(1'b1, 8);
    end
    nerr = 0;
    foreach (obs[i]) if (obs[i].is_err) nerr++;
    total++; if (nerr !== 300 || obs.size() !== 300) begin bad++; $display("FAIL sat_events: got %0d errors of %0d want 300", nerr, obs.size()); end
    total++; if (O_error_count !== model_errcnt()) begin bad++; $display("FAIL sat_errcnt: got %0d want %0d", O_error_count, model_errcnt()); end
    reset = 1'b1;
    @(posedge fe_clk); #1;
    reset = 1'b0; model_errs = 0; last_data = 8'h00;
    total++; if (O_error_count !== 8'h00) begin bad++; $display("FAIL sat_reset: got %0d want 0", O_error_count); end
    drive(1'b1, 5);
  endtask

  task automatic test_enable_drop;
    logic [7:0] b;
    logic [7:0] cnt0;
    obs.delete();
    I_baud_div = 16'd15;
    b = 8'($urandom);
    cnt0 = O_error_count;
    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(b[i], 16);
    drive(b[4], 8);
    I_enable = 1'b0;
    @(posedge fe_clk); #1;
    total++; if (O_busy !== 1'b0) begin bad++; $display("FAIL en_idle: got busy=%b want 0", O_busy); end
    drive(b[4], 7);
    for (int i = 5; i < 8; i++) drive(b[i], 16);
    drive(1'b1, 26);
    I_enable = 1'b1;
    drive(1'b1, 20);
    total++; if (obs.size() !== 0) begin bad++; $display("FAIL en_strobes: got %0d want 0", obs.size()); end
    total++; if (O_error_count !== cnt0) begin bad++; $display("FAIL en_errcnt: got %0d want %0d", O_error_count, cnt0); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    obs.delete(); exp_q.delete();
    send(8'h81, 1'b0, 16); drive(1'b1, 10);
    b = 8'($urandom);
    drive(1'b0, 16);
    for (int i = 0; i < 3; i++) drive(b[i], 16);
    reset = 1'b1;
    @(posedge fe_clk); #1;
    total++; if (O_data !== 8'h00 || O_data_valid !== 1'b0 || O_frame_error !== 1'b0) begin
      bad++; $display("FAIL rstmid_out: got %0h/%b/%b want 0/0/0", O_data, O_data_valid, O_frame_error); end
    total++; if (O_error_count !== 8'h00 || O_busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctl: got cnt=%0d busy=%b want 0/0", O_error_count, O_busy); end
    for (int i = 3; i < 8; i++) drive(b[i], 16);
    drive(1'b1, 16);
    reset = 1'b0; model_errs = 0;
    drive(1'b1, 5);
    obs.delete();
    b = 8'($urandom);
    send(b, 1'b1, 16); model_frame(b, 1'b1);
    drive(1'b1, 20);
    total++; if (obs.size() !== 1 || obs.size() == 1 && obs[0].data !== b) begin
      bad++; $display("FAIL rstmid_next: got %0d events data=%0h want 1 data=%0h", obs.size(), O_data, b); end
  endtask

  task automatic test_div1;
    logic [7:0] b;
    int c0;
    obs.delete();
    I_baud_div = 16'd1;
    b = 8'($urandom);
    c0 = cyc;
    send(b, 1'b1, 4);
    drive(1'b1, 12);
    total++; if (obs.size() !== 1 || obs.size() == 1 && obs[0].data !== b) begin
      bad++; $display("FAIL div1_data: got %0d events data=%0h want %0h", obs.size(), O_data, b); end
    if (obs.size() > 0) begin
      total++; if (obs[0].at !== c0 + 3 + 1 + 1 + 36) begin
        bad++; $display("FAIL div1_time: got %0d want %0d", obs[0].at - c0, 41); end
    end
  endtask

  task automatic test_random;
    int d;
    logic [7:0] b;
    logic stopb;
    for (int r = 0; r < 6; r++) begin
      obs.delete(); exp_q.delete();
      d = $urandom_range(3, 40);
      I_baud_div = 16'(d);
      for (int f = 0; f < 4; f++) begin
        b = 8'($urandom);
        stopb = ($urandom_range(0, 3) != 0);
        send(b, stopb, d + 1); model_frame(b, stopb);
        if (!stopb) drive(1'b1, 2 * (d + 1));
      end
      drive(1'b1, 3 * (d + 1));
      total++; if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", r, obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        total++; if (obs[i].is_err !== exp_q[i].is_err || (!exp_q[i].is_err && obs[i].data !== exp_q[i].data)) begin
          bad++; $display("FAIL rnd%0d_ev%0d: got err=%b %0h want err=%b %0h", r, i, obs[i].is_err, obs[i].data, exp_q[i].is_err, exp_q[i].data); end
      end
      total++; if (O_error_count !== model_errcnt()) begin bad++; $display("FAIL rnd%0d_errcnt: got %0d want %0d", r, O_error_count, model_errcnt()); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_saturate;
    test_enable_drop;
    test_reset_mid;
    test_div1;
    test_random;
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/swo_uart_rx.md
# swo_uart_rx

NRZ (UART-encoded) SWO receiver. It sits between the `swo` pin and the trace capture front end in `fe_clk`. It recovers 8-bit bytes from the asynchronous single-wire output and presents each byte as a one-cycle valid strobe to the capture logic, which consumes it the same way it consumes parallel-trace bytes. The bit period is set by a register-programmed divisor, and framing errors are flagged and counted.

## Interface
- `pDIV_WIDTH`, 16, width of the bit-period divisor.
- `fe_clk`  in  1  sole clock; all logic runs on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `I_enable`  in  1  receiver enable, level-sensitive.
- `I_baud_div`  in  pDIV_WIDTH  bit period in `fe_clk` cycles minus 1 (D). Quasi-static.
- `swo`  in  1  raw SWO line, asynchronous. Idles high.
- `O_data`  out  8  received byte, LSB first on the wire; held until the next valid byte.
- `O_data_valid`  out  1  one-cycle strobe; `O_data` is valid in that cycle.
- `O_frame_error`  out  1  one-cycle strobe; stop bit sampled low.
- `O_error_count`  out  8  framing-error count, saturating at 255.
- `O_busy`  out  1  high in any state other than IDLE.

## Operation
- Input synchronizer: 2-flop chain on `swo`; output `swo_s`. Reset value of both flops is 1.
- Effective divisor De = max(I_baud_div, 3). De is latched into an internal register on start detection and is constant for the rest of the frame.
- States:
  - IDLE: if `I_enable` and `swo_s`==0, go to START and load cnt = De>>1.
  - START: cnt decrements each cycle. At cnt==0, sample `swo_s`:
    - sample 0: go to DATA, cnt = De, bit index = 0.
    - sample 1: glitch; go to IDLE with no output.
  - DATA: at cnt==0, shift `swo_s` into the MSB of the shift register (shift right), reload cnt = De, and increment the bit index. After bit 7 is sampled, go to STOP.
  - STOP: at cnt==0, sample `swo_s`:
    - sample 1: pulse `O_data_valid`, update `O_data` with the shift register, go to IDLE.
    - sample 0: pulse `O_frame_error`, increment `O_error_count` (saturating), go to BRKWAIT. `O_data` is unchanged.
  - BRKWAIT: stay until `swo_s`==1, then go to IDLE. A held-low break therefore yields exactly one error.
- `I_enable` low in any state: go to IDLE on the next edge. A partial frame is discarded with no strobes; the counter is untouched.
- `reset`: state IDLE, all counters 0, `O_data`=0x00, `O_data_valid`=0, `O_frame_error`=0, `O_error_count`=0, `O_busy`=0, sync flops=1. Reset has priority over every other event, including mid-frame.
- `O_data_valid` and `O_frame_error` are never high in the same cycle.

## Timing
- Let t0 be the edge at which IDLE sees `swo_s`==0. A pin falling edge reaches `swo_s` 2 edges after capture.
- Start sample is at edge t0+1+(De>>1).
- Data bit i (i=0..7) is sampled at edge t0+1+(De>>1)+(i+1)(De+1).
- Stop bit is sampled at edge t0+1+(De>>1)+9(De+1). `O_data_valid` or `O_frame_error` is high for the one cycle following that edge.
- Back-to-back frames: IDLE is re-entered on the cycle after the stop sample. A start bit beginning immediately after a half-length stop bit is detected.
- Sampling tolerance: the sample point is mid-bit to within ±1 cycle. Cumulative baud mismatch up to ±4% over 10 bits must decode correctly.
- `O_busy` rises the cycle after t0 and falls the cycle IDLE is re-entered.
- Outputs are registered; there is no combinational path from `swo` to any output.

## Test plan
- D=15, byte 0xA5 (start, 1,0,1,0,0,1,0,1, stop): single `O_data_valid` at edge t0+1+7+144; `O_data`=0xA5; `O_frame_error` never asserted.
- D=15, back-to-back 0x00, 0xFF, 0x55 with no idle gap: exactly three valid strobes carrying 0x00, 0xFF, 0x55 in order.
- D=15, low glitch of 5 cycles on an idle line: START aborts at the start sample; no strobes; `O_busy` high for exactly 8 cycles.
- D=15, frame with stop bit 0, then line held low for 50 bit periods: one `O_frame_error`, `O_error_count`=1, no `O_data_valid`. After the line returns high, byte 0x3C decodes correctly.
- 300 consecutive framing errors: `O_error_count` reads 255 and stays there; `reset` returns it to 0.
- Abort cases:
  - `I_enable` dropped during bit 4 of a frame: IDLE next cycle, no strobes.
  - `reset` asserted mid-frame: all outputs at reset values the next cycle; the following frame decodes normally.
  - I_baud_div=1: behaves as D=3.
